i2c_slave_reg_ctrl: RTL
=======================

Name: i2c_slave_reg_ctrl

Overview:
Register-access controller that sequences the byte-stream I2C slave into a register-mapped peripheral. It consumes the slave's write-byte stream and interprets the first byte of each write as a register pointer and later bytes as auto-incrementing register writes. It serves the slave's read-byte requests by fetching from the register port at the current pointer. It sits between the I2C slave stream ports and a generic request/acknowledge register bus.

Parameters:
ADDR_WIDTH, 8, register pointer width (1..8); pointer byte truncated to low ADDR_WIDTH bits
TIMEOUT_CYCLES, 1024, cycles to wait for reg_ack (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_wr_tdata  in  8  written byte from slave master stream
s_axis_wr_tvalid  in  1  written byte valid
s_axis_wr_tready  out  1  written byte accepted
s_axis_wr_tlast  in  1  byte is last of the I2C write transaction
m_axis_rd_tdata  out  8  byte to slave read stream
m_axis_rd_tvalid  out  1  read byte valid
m_axis_rd_tready  in  1  slave requests a read byte
m_axis_rd_tlast  out  1  constant 0
reg_req  out  1  register access request, held until reg_ack
reg_we  out  1  1 = write, 0 = read; stable while reg_req
reg_addr  out  ADDR_WIDTH  register address; stable while reg_req
reg_wdata  out  8  write data; stable while reg_req
reg_ack  in  1  access complete; reg_rdata valid this cycle on reads
reg_rdata  in  8  read data
reg_ptr  out  ADDR_WIDTH  current pointer
busy  out  1  state != IDLE
err_count  out  8  timeout count (only with the optional feature)

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: all outputs 0. Pointer = 0. first_byte flag = 1. State = IDLE.
- States: IDLE, WR_REQ, RD_REQ, RD_HOLD.
- IDLE, write path: s_axis_wr_tready = 1 in IDLE only, so a byte is accepted in the cycle it is valid.
  - If first_byte = 1: pointer <= tdata[ADDR_WIDTH-1:0]; first_byte <= tlast; stay in IDLE. No register access.
  - Else: latch reg_addr = pointer and reg_wdata = tdata; first_byte <= tlast; go to WR_REQ.
- IDLE, read path: with m_axis_rd_tready = 1 and no write byte valid, latch reg_addr = pointer and go to RD_REQ.
- Priority: a write byte wins over a read request in the same cycle.
- WR_REQ: reg_req = 1, reg_we = 1. On reg_ack: pointer++, return to IDLE.
- RD_REQ: reg_req = 1, reg_we = 0. On reg_ack: capture reg_rdata into m_axis_rd_tdata, go to RD_HOLD.
- RD_HOLD: m_axis_rd_tvalid = 1. On tready & tvalid: pointer++, first_byte <= 1, return to IDLE.
- Latency: IDLE to reg_req asserted is 1 cycle. reg_ack to m_axis_rd_tvalid is 1 cycle.
- reg_ack outside WR_REQ/RD_REQ is ignored.
- Pointer wraps modulo 2^ADDR_WIDTH (0xFF + 1 = 0x00 at ADDR_WIDTH = 8).
- A pointer-only write (single byte with tlast) sets the pointer and leaves first_byte = 1.
- Reset mid-access: reg_req drops in the next cycle; a late reg_ack is ignored; a held read byte is discarded.

Optional Feature:
I2C_REG_CTRL_TIMEOUT_EN
- Defined: a counter runs in WR_REQ/RD_REQ. When it reaches TIMEOUT_CYCLES without reg_ack:
  - reg_req drops and err_count increments, saturating at 255.
  - Write is dropped; pointer still increments.
  - Read returns 0xFF via RD_HOLD.
- Undefined: wait for reg_ack indefinitely; err_count is tied to 0 and no counter logic is built.

Decomposition:
- Shared package i2c_pkg holds:
  - the state encoding typedef for the controller;
  - the constant RD_TIMEOUT_DATA = 8'hFF;
  - a default ADDR_WIDTH constant.
- No sub-module is needed. The timeout counter stays inline under the macro.

Test Plan:
- Write stream 0x10 (tlast=0), 0xAA, 0xBB (tlast=1) -> two register writes: addr 0x10 data 0xAA, then addr 0x11 data 0xBB; reg_ptr = 0x12; first_byte = 1.
- Pointer write 0x20 (tlast=1), then three read requests with reg_rdata 0x01/0x02/0x03 -> m_axis bytes 0x01, 0x02, 0x03 from addrs 0x20, 0x21, 0x22; reg_ptr = 0x23.
- Pointer 0xFF, then write 0x55 -> write at 0xFF; reg_ptr = 0x00 (wrap).
- Write byte and m_axis_rd_tready asserted in the same IDLE cycle -> write is serviced first, then the read uses the incremented pointer.
- rst asserted during RD_REQ, with reg_ack 2 cycles later -> reg_req = 0 the cycle after rst, m_axis_rd_tvalid stays 0, reg_ptr = 0.
- With I2C_REG_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 16, read with no ack -> reg_req drops after 16 cycles, read byte 0xFF, err_count = 1.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register-access controller.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_HOLD = 2'd3
  } ctrl_state_t;

  localparam logic [7:0] RD_TIMEOUT_DATA   = 8'hFF;
  localparam int         DEFAULT_ADDR_WIDTH = 8;

endpackage

// File: rtl/i2c_slave_reg_ctrl.sv
// Bridges the I2C slave byte streams onto a req/ack register bus with an auto-incrementing pointer.
// Optional register-bus timeout is built only when I2C_REG_CTRL_TIMEOUT_EN is defined.
module i2c_slave_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_wr_tdata,
  input  logic                  s_axis_wr_tvalid,
  output logic                  s_axis_wr_tready,
  input  logic                  s_axis_wr_tlast,
  output logic [7:0]            m_axis_rd_tdata,
  output logic                  m_axis_rd_tvalid,
  input  logic                  m_axis_rd_tready,
  output logic                  m_axis_rd_tlast,
  output logic                  reg_req,
  output logic                  reg_we,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  input  logic                  reg_ack,
  input  logic [7:0]            reg_rdata,
  output logic [ADDR_WIDTH-1:0] reg_ptr,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  ctrl_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic [7:0]            rdata_q, rdata_d;
  logic                  first_q, first_d;
  logic                  in_access;
  logic                  timeout;

  assign in_access = (state_q == WR_REQ) || (state_q == RD_REQ);

`ifdef I2C_REG_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic [7:0]       err_q;

  // Fires on the TIMEOUT_CYCLES-th cycle of an unacknowledged request.
  assign timeout = in_access && !reg_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      err_q <= '0;
    end else begin
      if (in_access && !reg_ack && !timeout) tmo_q <= tmo_q + 1'b1;
      else                                   tmo_q <= '0;
      if (timeout && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
    end
  end

  assign err_count = err_q;
`else
  assign timeout   = 1'b0;
  assign err_count = 8'd0;
`endif

  // Streams use valid/ready: a byte moves on a clock edge where both are high.
  // Write bytes are accepted only in IDLE and take priority over a read request.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (s_axis_wr_tvalid) begin
          first_d = s_axis_wr_tlast;
          if (first_q) begin
            ptr_d = s_axis_wr_tdata[ADDR_WIDTH-1:0];
          end else begin
            addr_d  = ptr_q;
            wdata_d = s_axis_wr_tdata;
            state_d = WR_REQ;
          end
        end else if (m_axis_rd_tready) begin
          addr_d  = ptr_q;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        // A timed-out write is dropped but still advances the pointer.
        if (reg_ack || timeout) begin
          ptr_d   = ptr_q + PTR_ONE;
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        if (reg_ack) begin
          rdata_d = reg_rdata;
          state_d = RD_HOLD;
        end else if (timeout) begin
          rdata_d = RD_TIMEOUT_DATA;
          state_d = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (m_axis_rd_tready) begin
          ptr_d   = ptr_q + PTR_ONE;
          first_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      first_q <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign s_axis_wr_tready = (state_q == IDLE) && !rst;
  assign m_axis_rd_tdata  = rdata_q;
  assign m_axis_rd_tvalid = (state_q == RD_HOLD);
  assign m_axis_rd_tlast  = 1'b0;
  assign reg_req          = in_access;
  assign reg_we           = (state_q == WR_REQ);
  assign reg_addr         = addr_q;
  assign reg_wdata        = wdata_q;
  assign reg_ptr          = ptr_q;
  assign busy             = (state_q != IDLE);

endmodule
